// File: rtl/div_ratio_meter_pkg.sv
// Shared fractional-N definitions: ratio-meter FSM encoding and derived widths.
package div_ratio_meter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARM     = 2'd1,
      ST_MEASURE = 2'd2,
      ST_DONE    = 2'd3
   } meter_state_e;

   // Sum of 2^avg_log2 periods of at most 2^cnt_w-1 each cannot exceed this width.
   function automatic int unsigned acc_width(input int unsigned cnt_w,
                                             input int unsigned avg_log2);
      return cnt_w + avg_log2;
   endfunction

endpackage

// File: rtl/fout_edge_det.sv
// Registers Fout and flags its rising edge; the register resets high so a
// level already high at reset release does not count as an edge.
module fout_edge_det (
   input  logic clk,
   input  logic rst_n,
   input  logic fout,
   output logic rise_c
);

   logic fout_d;
   logic fout_q;

   always_comb begin
      fout_d = fout;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) fout_q <= 1'b1;
      else        fout_q <= fout_d;
   end

   assign rise_c = fout & ~fout_q;

endmodule

// File: rtl/div_ratio_meter.sv
// Measures the average Fin/Fout division ratio over 2^AVG_LOG2 Fout periods,
// plus the shortest and longest single period seen in that window.
module div_ratio_meter
   import div_ratio_meter_pkg::*;
#(
   parameter int unsigned INT_WIDTH  = 8,
   parameter int unsigned FRAC_WIDTH = 24,
   parameter int unsigned AVG_LOG2   = 16,
   parameter int unsigned CNT_WIDTH  = INT_WIDTH + 4
) (
   input  logic                  Fin,
   input  logic                  rst_n,
   input  logic                  Fout,
   input  logic                  start,
   output logic                  busy,
   output logic                  valid,
   output logic                  err,
   output logic [INT_WIDTH-1:0]  Integer_meas,
   output logic [FRAC_WIDTH-1:0] Fraction_meas,
   output logic [CNT_WIDTH-1:0]  per_min,
   output logic [CNT_WIDTH-1:0]  per_max
);

   localparam int unsigned ACC_W   = acc_width(CNT_WIDTH, AVG_LOG2);
   localparam int unsigned SAT_LSB = AVG_LOG2 + INT_WIDTH;
   localparam int unsigned FRAC_SH = FRAC_WIDTH - AVG_LOG2;

   logic rise_c;

   fout_edge_det u_edge (
      .clk    (Fin),
      .rst_n  (rst_n),
      .fout   (Fout),
      .rise_c (rise_c)
   );

   meter_state_e          state_d, state_q;
   logic [CNT_WIDTH-1:0]  cnt_d, cnt_q;
   logic [AVG_LOG2-1:0]   idx_d, idx_q;
   logic [ACC_W-1:0]      acc_d, acc_q;
   logic [CNT_WIDTH-1:0]  pmin_d, pmin_q;
   logic [CNT_WIDTH-1:0]  pmax_d, pmax_q;
   logic                  fin_d, fin_q;
   logic                  busy_d, busy_q;
   logic                  valid_d, valid_q;
   logic                  err_d, err_q;
   logic [INT_WIDTH-1:0]  int_d, int_q;
   logic [FRAC_WIDTH-1:0] frac_d, frac_q;
   logic [CNT_WIDTH-1:0]  per_min_d, per_min_q;
   logic [CNT_WIDTH-1:0]  per_max_d, per_max_q;

   logic                  cnt_full_c;
   logic                  sat_c;

   assign cnt_full_c = &cnt_q;
   assign sat_c      = (acc_q >> SAT_LSB) != '0;

   // Next-state and datapath; results are published one cycle after the
   // last period so they come from the fully updated accumulator.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      acc_d     = acc_q;
      pmin_d    = pmin_q;
      pmax_d    = pmax_q;
      fin_d     = 1'b0;
      busy_d    = busy_q;
      valid_d   = valid_q;
      err_d     = err_q;
      int_d     = int_q;
      frac_d    = frac_q;
      per_min_d = per_min_q;
      per_max_d = per_max_q;

      if (fin_q) begin
         int_d     = sat_c ? '1 : acc_q[AVG_LOG2 +: INT_WIDTH];
         frac_d    = FRAC_WIDTH'(acc_q[AVG_LOG2-1:0]) << FRAC_SH;
         per_min_d = pmin_q;
         per_max_d = pmax_q;
         valid_d   = 1'b1;
         err_d     = sat_c;
      end

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start && !fin_q) begin
               state_d = ST_ARM;
               cnt_d   = '0;
               busy_d  = 1'b1;
               valid_d = 1'b0;
               err_d   = 1'b0;
            end
         end
         ST_ARM: begin
            if (cnt_full_c) begin
               state_d = ST_DONE;
               busy_d  = 1'b0;
               valid_d = 1'b0;
               err_d   = 1'b1;
            end else if (rise_c) begin
               state_d = ST_MEASURE;
               cnt_d   = CNT_WIDTH'(1);
               acc_d   = '0;
               idx_d   = '0;
               pmin_d  = '1;
               pmax_d  = '0;
            end else begin
               cnt_d = cnt_q + CNT_WIDTH'(1);
            end
         end
         ST_MEASURE: begin
            if (cnt_full_c) begin
               state_d = ST_DONE;
               busy_d  = 1'b0;
               valid_d = 1'b0;
               err_d   = 1'b1;
            end else if (rise_c) begin
               acc_d = acc_q + ACC_W'(cnt_q);
               if (cnt_q < pmin_q) pmin_d = cnt_q;
               if (cnt_q > pmax_q) pmax_d = cnt_q;
               cnt_d = CNT_WIDTH'(1);
               idx_d = idx_q + AVG_LOG2'(1);
               if (&idx_q) begin
                  state_d = ST_DONE;
                  busy_d  = 1'b0;
                  fin_d   = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + CNT_WIDTH'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge Fin or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         idx_q     <= '0;
         acc_q     <= '0;
         pmin_q    <= '0;
         pmax_q    <= '0;
         fin_q     <= 1'b0;
         busy_q    <= 1'b0;
         valid_q   <= 1'b0;
         err_q     <= 1'b0;
         int_q     <= '0;
         frac_q    <= '0;
         per_min_q <= '0;
         per_max_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         acc_q     <= acc_d;
         pmin_q    <= pmin_d;
         pmax_q    <= pmax_d;
         fin_q     <= fin_d;
         busy_q    <= busy_d;
         valid_q   <= valid_d;
         err_q     <= err_d;
         int_q     <= int_d;
         frac_q    <= frac_d;
         per_min_q <= per_min_d;
         per_max_q <= per_max_d;
      end
   end

   assign busy          = busy_q;
   assign valid         = valid_q;
   assign err           = err_q;
   assign Integer_meas  = int_q;
   assign Fraction_meas = frac_q;
   assign per_min       = per_min_q;
   assign per_max       = per_max_q;

endmodule

// File: tb/tb_div_ratio_meter.sv
// Directed bench for div_ratio_meter: a period-sum model pushes expected
// results to a queue, which are popped when each measurement completes.
module tb_div_ratio_meter;

   localparam int unsigned IW = 7;
   localparam int unsigned FW = 24;
   localparam int unsigned AL = 4;
   localparam int unsigned CW = 8;
   localparam int unsigned NP = 1 << AL;

   logic          Fin;
   logic          rst_n;
   logic          Fout;
   logic          start;
   logic          busy;
   logic          valid;
   logic          err;
   logic [IW-1:0] Integer_meas;
   logic [FW-1:0] Fraction_meas;
   logic [CW-1:0] per_min;
   logic [CW-1:0] per_max;

   div_ratio_meter #(
      .INT_WIDTH  (IW),
      .FRAC_WIDTH (FW),
      .AVG_LOG2   (AL),
      .CNT_WIDTH  (CW)
   ) dut (
      .Fin           (Fin),
      .rst_n         (rst_n),
      .Fout          (Fout),
      .start         (start),
      .busy          (busy),
      .valid         (valid),
      .err           (err),
      .Integer_meas  (Integer_meas),
      .Fraction_meas (Fraction_meas),
      .per_min       (per_min),
      .per_max       (per_max)
   );

   initial Fin = 1'b0;
   always #5 Fin = ~Fin;

   typedef struct {
      logic          valid;
      logic          err;
      logic [IW-1:0] intv;
      logic [FW-1:0] frac;
      logic [CW-1:0] pmin;
      logic [CW-1:0] pmax;
   } exp_t;

   exp_t sb_q[$];
   exp_t last;
   int   checks;
   int   errors;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge Fin);
         #1;
      end
   endtask

   // Reference: average of the period list, saturating integer part.
   task automatic push_model(input int per[$]);
      exp_t    e;
      longint  sum;
      int      mn;
      int      mx;
      logic    sat;
      sum = 0;
      mn  = 1 << CW;
      mx  = 0;
      foreach (per[i]) begin
         sum += per[i];
         if (per[i] < mn) mn = per[i];
         if (per[i] > mx) mx = per[i];
      end
      sat     = (sum >> (AL + IW)) != 0;
      e.valid = 1'b1;
      e.err   = sat;
      e.intv  = sat ? {IW{1'b1}} : IW'(sum >> AL);
      e.frac  = FW'(sum % NP) << (FW - AL);
      e.pmin  = CW'(mn);
      e.pmax  = CW'(mx);
      sb_q.push_back(e);
      last = e;
   endtask

   task automatic push_timeout();
      exp_t e;
      e       = last;
      e.valid = 1'b0;
      e.err   = 1'b1;
      sb_q.push_back(e);
   endtask

   // Start, then one arming edge followed by the listed periods.
   task automatic drive_meas(input int per[$], input bit extra_start);
      int h;
      start = 1'b1;
      cyc(1);
      start = 1'b0;
      cyc(3);
      chk("busy_after_start", 64'(busy), 64'd1);
      chk("valid_clr_on_start", 64'(valid), 64'd0);
      foreach (per[i]) begin
         h    = per[i] / 2;
         Fout = 1'b1;
         cyc(h);
         Fout = 1'b0;
         if (extra_start && i == 5) begin
            start = 1'b1;
            cyc(1);
            start = 1'b0;
            cyc(per[i] - h - 1);
         end else begin
            cyc(per[i] - h);
         end
      end
      Fout = 1'b1;
      cyc(2);
      Fout = 1'b0;
   endtask

   task automatic wait_check(input string tag);
      exp_t e;
      int   n;
      n = 0;
      while (busy && n < 400) begin
         cyc(1);
         n++;
      end
      chk({tag, "_done_in_budget"}, 64'(busy), 64'd0);
      cyc(1);
      if (sb_q.size() == 0) begin
         errors++;
         $error("FAIL %s scoreboard_empty observed=0 expected=1", tag);
      end else begin
         e = sb_q.pop_front();
         chk({tag, "_valid"}, 64'(valid), 64'(e.valid));
         chk({tag, "_err"}, 64'(err), 64'(e.err));
         chk({tag, "_int"}, 64'(Integer_meas), 64'(e.intv));
         chk({tag, "_frac"}, 64'(Fraction_meas), 64'(e.frac));
         chk({tag, "_pmin"}, 64'(per_min), 64'(e.pmin));
         chk({tag, "_pmax"}, 64'(per_max), 64'(e.pmax));
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_busy"}, 64'(busy), 64'd0);
      chk({tag, "_valid"}, 64'(valid), 64'd0);
      chk({tag, "_err"}, 64'(err), 64'd0);
      chk({tag, "_int"}, 64'(Integer_meas), 64'd0);
      chk({tag, "_frac"}, 64'(Fraction_meas), 64'd0);
      chk({tag, "_pmin"}, 64'(per_min), 64'd0);
      chk({tag, "_pmax"}, 64'(per_max), 64'd0);
   endtask

   initial begin
      int per[$];
      int n;
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      Fout   = 1'b0;
      start  = 1'b0;
      last   = '{1'b0, 1'b0, '0, '0, '0, '0};
      cyc(3);
      chk_zero("reset");
      rst_n = 1'b1;
      cyc(2);

      // Constant period of 120.
      per = {};
      for (int i = 0; i < NP; i++) per.push_back(120);
      push_model(per);
      drive_meas(per, 1'b0);
      wait_check("const120");

      // Alternating 120/121: half-count fraction.
      per = {};
      for (int i = 0; i < NP; i++) per.push_back((i % 2 == 0) ? 120 : 121);
      push_model(per);
      drive_meas(per, 1'b0);
      wait_check("alt120_121");

      // Random periods.
      per = {};
      for (int i = 0; i < NP; i++) per.push_back(int'($urandom_range(90, 125)));
      push_model(per);
      drive_meas(per, 1'b0);
      wait_check("random");

      // Average of 200 overflows a 7-bit integer part.
      per = {};
      for (int i = 0; i < NP; i++) per.push_back(200);
      push_model(per);
      drive_meas(per, 1'b0);
      wait_check("saturate");

      // Fout held low: counter timeout, previous results held.
      push_timeout();
      start = 1'b1;
      cyc(1);
      start = 1'b0;
      n = 0;
      while (busy && n < 300) begin
         cyc(1);
         n++;
      end
      chk("timeout_latency_ok", 64'(n <= 256), 64'd1);
      wait_check("timeout");

      // Reset in the middle of a measurement.
      start = 1'b1;
      cyc(1);
      start = 1'b0;
      cyc(2);
      for (int i = 0; i < 4; i++) begin
         Fout = 1'b1;
         cyc(50);
         Fout = 1'b0;
         cyc(60);
      end
      rst_n = 1'b0;
      cyc(2);
      chk_zero("mid_reset");
      rst_n = 1'b1;
      cyc(3);
      chk("post_reset_valid", 64'(valid), 64'd0);

      // Clean result afterwards, with a second start ignored while busy.
      per = {};
      for (int i = 0; i < NP; i++) per.push_back(120);
      push_model(per);
      drive_meas(per, 1'b1);
      wait_check("after_reset");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
